fsk_symbol_demod: RTL

- Receiver-side stage directly downstream of the 4-tone divided-clock modulator.
- Samples the modulator's square-wave output on the same system clock and measures the rising-edge-to-rising-edge period in clk cycles.
- Classifies each period into the 2-bit symbol that selected it: period 2 -> 0, 4 -> 1, 8 -> 2, 16 -> 3.
- Confirms the symbol over several consecutive periods, then presents it with a valid level and a change strobe.

---
 rtl/fsk_symbol_demod_if.sv | 34 +++
 rtl/fsk_symbol_demod.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fsk_symbol_demod_if.sv
// ---------------------------------------------------------------------------
// fsk_symbol_demod_if
//   Groups the demodulator's signal-level connections.
//   in          : modulated square wave into the demodulator
//   sym         : confirmed 2-bit symbol
//   sym_valid   : high while a confirmed symbol is held
//   sym_strobe  : one-cycle pulse when sym is loaded with a new/changed value
//   err         : one-cycle pulse on an out-of-range period or a timeout
//   master : the side that drives in and observes the symbol outputs
//   slave  : the demodulator itself
// ---------------------------------------------------------------------------
interface fsk_symbol_demod_if;
    logic       in;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_strobe;
    logic       err;

    modport master (
        output in,
        input  sym,
        input  sym_valid,
        input  sym_strobe,
        input  err
    );

    modport slave (
        input  in,
        output sym,
        output sym_valid,
        output sym_strobe,
        output err
    );
endinterface

// File: rtl/fsk_symbol_demod.sv
// ---------------------------------------------------------------------------
// fsk_symbol_demod
//   Recovers the 2-bit symbol from the 4-tone divided-clock modulator by
//   measuring the rising-edge-to-rising-edge period of its square wave in clk
//   cycles (2/4/8/16 -> symbol 0/1/2/3). A symbol is confirmed once
//   LOCK_COUNT consecutive periods fall into the same class.
//
//   Ports:
//     clk    : system clock (same clock as the modulator's divider chain)
//     reset  : synchronous, active-low reset
//     bus    : fsk_symbol_demod_if.slave (in, sym, sym_valid, sym_strobe, err)
//
//   Parameters:
//     CNT_W      : period counter width
//     TIMEOUT    : cycles without a rising edge before lock is dropped
//                  (must be < 2**CNT_W)
//     LOCK_COUNT : consecutive same-class periods to confirm a symbol (1..7)
//
//   Build option:
//     FSK_DEMOD_SYNC_EN : when defined, two synchronizer flops precede the
//                         edge detector so an asynchronous 'in' can be used.
//                         Adds 2 cycles of latency; periods are unchanged.
// ---------------------------------------------------------------------------
module fsk_symbol_demod #(
    parameter int CNT_W      = 6,
    parameter int TIMEOUT    = 32,
    parameter int LOCK_COUNT = 3
) (
    input logic               clk,
    input logic               reset,
    fsk_symbol_demod_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       MATCH_MAX = 3'(LOCK_COUNT);

    // Saturating period counter increment.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
        if (c >= CNT_MAX) begin
            return CNT_MAX;
        end
        return c + CNT_ONE;
    endfunction

    // Saturating consecutive-match increment.
    function automatic logic [2:0] match_next(input logic [2:0] m);
        if (m >= MATCH_MAX) begin
            return MATCH_MAX;
        end
        return m + 3'd1;
    endfunction

    // Returns {class_ok, class}. Ranges are centred on the nominal periods
    // so that a jittered edge still lands in the right bin.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        int unsigned pv;
        pv = 32'(p);
        if (pv == 32'd2) begin
            return {1'b1, 2'd0};
        end else if (pv >= 32'd3 && pv <= 32'd5) begin
            return {1'b1, 2'd1};
        end else if (pv >= 32'd6 && pv <= 32'd11) begin
            return {1'b1, 2'd2};
        end else if (pv >= 32'd12 && pv <= 32'd23) begin
            return {1'b1, 2'd3};
        end
        return 3'b000;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       match;
    logic [1:0]       cand;
    logic             in_d1;
    logic             in_d2;
    logic             in_src;
    logic             rise;

    logic [1:0]       sym_r;
    logic             sym_valid_r;
    logic             sym_strobe_r;
    logic             err_r;

    logic             cls_ok;
    logic [1:0]       cls;
    logic [1:0]       upd_cand;
    logic [2:0]       upd_match;
    logic             hit;

`ifdef FSK_DEMOD_SYNC_EN
    logic in_s1;
    logic in_s2;

    // Input synchronizer
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_s1 <= 1'b0;
            in_s2 <= 1'b0;
        end else begin
            in_s1 <= bus.in;
            in_s2 <= in_s1;
        end
    end

    assign in_src = in_s2;
`else
    assign in_src = bus.in;
`endif

    assign rise = in_d1 & ~in_d2;

    // Candidate/match update for the period ending on this rise.
    always_comb begin
        {cls_ok, cls} = classify(cnt);
        upd_cand  = cand;
        upd_match = 3'd0;
        if (cls_ok) begin
            if (cls == cand && match != 3'd0) begin
                upd_match = match_next(match);
            end else begin
                upd_cand  = cls;
                upd_match = 3'd1;
            end
        end
        hit = cls_ok && (upd_match == MATCH_MAX);
    end

    // Edge detect, period counter and symbol FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            match        <= 3'd0;
            cand         <= 2'd0;
            in_d1        <= 1'b0;
            in_d2        <= 1'b0;
            sym_r        <= 2'd0;
            sym_valid_r  <= 1'b0;
            sym_strobe_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            in_d1        <= in_src;
            in_d2        <= in_d1;
            cnt          <= rise ? CNT_ONE : cnt_next(cnt);
            sym_strobe_r <= 1'b0;
            err_r        <= 1'b0;

            case (state)
                IDLE: begin
                    // First edge only starts the measurement; there is no
                    // earlier edge to measure a period against.
                    if (rise) begin
                        state <= MEASURE;
                        match <= 3'd0;
                    end
                end

                MEASURE, LOCKED: begin
                    if (rise) begin
                        // A rise coinciding with cnt==TIMEOUT takes priority.
                        cand  <= upd_cand;
                        match <= upd_match;
                        if (!cls_ok) begin
                            err_r <= 1'b1;
                            if (state == LOCKED) begin
                                sym_valid_r <= 1'b0;
                                state       <= MEASURE;
                            end
                        end else if (hit) begin
                            if (state == MEASURE) begin
                                sym_r        <= upd_cand;
                                sym_valid_r  <= 1'b1;
                                sym_strobe_r <= 1'b1;
                                state        <= LOCKED;
                            end else if (upd_cand != sym_r) begin
                                sym_r        <= upd_cand;
                                sym_strobe_r <= 1'b1;
                            end
                        end
                    end else if (cnt == CNT_MAX) begin
                        // Leaving for IDLE makes this a single pulse.
                        err_r       <= 1'b1;
                        sym_valid_r <= 1'b0;
                        match       <= 3'd0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sym        = sym_r;
    assign bus.sym_valid  = sym_valid_r;
    assign bus.sym_strobe = sym_strobe_r;
    assign bus.err        = err_r;

endmodule
